// File: rtl/yarvi_scoreboard.sv
// yarvi_scoreboard: RAW/WAW interlock sitting between decode and execute.
// Short ops retire through a fixed delay line, long ops on explicit writeback.
module yarvi_scoreboard #(
    parameter int ALU_LAT  = 2,
    parameter int MAX_LONG = 4,
    parameter int CW       = $clog2(MAX_LONG + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          issue_valid,
    input  logic          issue_use_rs1,
    input  logic [4:0]    issue_rs1,
    input  logic          issue_use_rs2,
    input  logic [4:0]    issue_rs2,
    input  logic [4:0]    issue_rd,
    input  logic          issue_long,
    output logic          issue_ready,
    input  logic          wb_valid,
    input  logic [4:0]    wb_rd,
    input  logic          flush,
    output logic [31:0]   busy,
    output logic [CW-1:0] long_outstanding,
    output logic          err
);

    logic [4:0]  dl [ALU_LAT];
    logic [31:0] short_busy;
    logic [31:0] long_busy;
    logic        rd_nz;
    logic        long_full;
    logic        hazard;
    logic        fire;
    logic        long_set;
    logic        wb_hit;
    logic        wb_miss;

    // Stage entries of 0 mean "empty"; x0 is never tracked.
    always_comb begin
        short_busy = '0;
        for (int i = 0; i < ALU_LAT; i++)
            short_busy[dl[i]] = 1'b1;
        short_busy[0] = 1'b0;
    end

    assign busy      = short_busy | long_busy;
    assign rd_nz     = issue_rd != 5'd0;
    assign long_full = long_outstanding == CW'(MAX_LONG);

    assign hazard = (issue_use_rs1 & busy[issue_rs1])
                  | (issue_use_rs2 & busy[issue_rs2])
                  | (rd_nz & busy[issue_rd])
                  | (issue_long & rd_nz & long_full);

    assign issue_ready = !hazard;
    assign fire        = issue_valid & issue_ready & !flush;
    assign long_set    = fire & issue_long & rd_nz;

    assign wb_hit  = wb_valid & (wb_rd != 5'd0) & long_busy[wb_rd];
    assign wb_miss = wb_valid & (wb_rd != 5'd0) & !long_busy[wb_rd];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ALU_LAT; i++)
                dl[i] <= 5'd0;
            long_busy        <= '0;
            long_outstanding <= '0;
            err              <= 1'b0;
        end else begin
            if (flush) begin
                for (int i = 0; i < ALU_LAT; i++)
                    dl[i] <= 5'd0;
            end else begin
                dl[0] <= (fire && !issue_long) ? issue_rd : 5'd0;
                for (int i = 1; i < ALU_LAT; i++)
                    dl[i] <= dl[i-1];
            end
            if (long_set)
                long_busy[issue_rd] <= 1'b1;
            if (wb_hit)
                long_busy[wb_rd] <= 1'b0;
            if (long_set && !wb_hit)
                long_outstanding <= long_outstanding + CW'(1);
            else if (!long_set && wb_hit)
                long_outstanding <= long_outstanding - CW'(1);
            if (wb_miss)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_yarvi_scoreboard.sv
// tb_yarvi_scoreboard: directed spec scenarios plus random traffic,
// checked by a queue-fed monitor against a per-register countdown model.
module tb_yarvi_scoreboard;

    localparam int ALU_LAT  = 2;
    localparam int MAX_LONG = 4;
    localparam int CW       = $clog2(MAX_LONG + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          issue_valid = 1'b0;
    logic          issue_use_rs1 = 1'b0;
    logic [4:0]    issue_rs1 = '0;
    logic          issue_use_rs2 = 1'b0;
    logic [4:0]    issue_rs2 = '0;
    logic [4:0]    issue_rd = '0;
    logic          issue_long = 1'b0;
    logic          issue_ready;
    logic          wb_valid = 1'b0;
    logic [4:0]    wb_rd = '0;
    logic          flush = 1'b0;
    logic [31:0]   busy;
    logic [CW-1:0] long_outstanding;
    logic          err;

    yarvi_scoreboard #(.ALU_LAT(ALU_LAT), .MAX_LONG(MAX_LONG)) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid),
        .issue_use_rs1(issue_use_rs1), .issue_rs1(issue_rs1),
        .issue_use_rs2(issue_use_rs2), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_long(issue_long),
        .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .busy(busy), .long_outstanding(long_outstanding), .err(err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        ready;
        logic [31:0] busy;
        int          lo;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;

    // Reference model: remaining busy cycles per register, long-op set.
    int   short_rem [32];
    bit   long_set [32];
    int   cnt;
    bit   m_err;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] m_busy();
        logic [31:0] b = '0;
        for (int r = 1; r < 32; r++)
            b[r] = (short_rem[r] > 0) || long_set[r];
        return b;
    endfunction

    function automatic bit m_ready(bit u1, bit [4:0] r1, bit u2,
                                  bit [4:0] r2, bit [4:0] rd, bit lg);
        logic [31:0] b = m_busy();
        if (u1 && b[r1]) return 0;
        if (u2 && b[r2]) return 0;
        if (rd != 0 && b[rd]) return 0;
        if (lg && rd != 0 && cnt == MAX_LONG) return 0;
        return 1;
    endfunction

    task automatic m_clear();
        for (int r = 0; r < 32; r++) begin
            short_rem[r] = 0;
            long_set[r]  = 0;
        end
        cnt   = 0;
        m_err = 0;
    endtask

    task automatic step(input bit v, bit u1, bit [4:0] r1, bit u2,
                        bit [4:0] r2, bit [4:0] rd, bit lg, bit wv,
                        bit [4:0] wr, bit fl, bit rst);
        exp_t e;
        bit   rdy;
        @(negedge clock);
        issue_valid = v;  issue_use_rs1 = u1; issue_rs1 = r1;
        issue_use_rs2 = u2; issue_rs2 = r2; issue_rd = rd;
        issue_long = lg;  wb_valid = wv; wb_rd = wr;
        flush = fl;       reset = rst;
        rdy     = m_ready(u1, r1, u2, r2, rd, lg);
        e.ready = rdy;
        e.busy  = m_busy();
        e.lo    = cnt;
        e.err   = m_err;
        q.push_back(e);
        if (rst) begin
            m_clear();
        end else begin
            for (int r = 0; r < 32; r++)
                if (short_rem[r] > 0) short_rem[r]--;
            if (fl)
                for (int r = 0; r < 32; r++) short_rem[r] = 0;
            if (wv && wr != 0) begin
                if (long_set[wr]) begin
                    long_set[wr] = 0;
                    cnt--;
                end else begin
                    m_err = 1;
                end
            end
            if (v && rdy && !fl && rd != 0) begin
                if (lg) begin
                    long_set[rd] = 1;
                    cnt++;
                end else begin
                    short_rem[rd] = ALU_LAT;
                end
            end
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            while (q.size() > 0) begin
                e = q.pop_front();
                chk("mon_ready", issue_ready, e.ready);
                chk("mon_busy", busy, e.busy);
                chk("mon_long_outstanding", long_outstanding, e.lo);
                chk("mon_err", err, e.err);
            end
        end
    end

    initial begin : stim
        m_clear();
        do_reset();
        do_reset();

        // Reset state, ready for any inputs
        step(0, 1, 13, 1, 22, 17, 1, 0, 0, 0, 0);
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_lo", long_outstanding, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", issue_ready, 1);

        // Short rd=5, ALU_LAT busy cycles
        step(1, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0);
        for (int c = 1; c <= 2; c++) begin
            step(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
            #3;
            chk("short_stall_ready", issue_ready, 0);
            chk("short_busy5", busy[5], 1);
        end
        step(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("short_release_ready", issue_ready, 1);
        chk("short_release_busy5", busy[5], 0);

        // Long rd=7, retired by wb at cycle 10
        step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
        for (int c = 1; c <= 9; c++) begin
            step(1, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0);
            #3;
            chk("long_stall_ready", issue_ready, 0);
        end
        chk("long_lo_1", long_outstanding, 1);
        step(1, 0, 0, 1, 7, 0, 0, 1, 7, 0, 0);
        #3;
        chk("long_wb_cycle_ready", issue_ready, 0);
        step(1, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0);
        #3;
        chk("long_after_wb_ready", issue_ready, 1);
        chk("long_lo_0", long_outstanding, 0);

        // MAX_LONG limit
        for (int r = 1; r <= 4; r++)
            step(1, 0, 0, 0, 0, 5'(r), 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0);
        #3;
        chk("full_lo", long_outstanding, MAX_LONG);
        chk("full_long_ready", issue_ready, 0);
        step(0, 0, 0, 0, 0, 8, 0, 0, 0, 0, 0);
        #3;
        chk("full_short_ready", issue_ready, 1);
        step(0, 0, 0, 0, 0, 8, 1, 1, 2, 0, 0);
        #3;
        chk("full_wb_cycle_ready", issue_ready, 0);
        step(0, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0);
        #3;
        chk("full_after_wb_ready", issue_ready, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0);

        // x0 never tracked
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("x0_ready", issue_ready, 1);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        #3;
        chk("x0_busy0", busy[0], 0);
        chk("x0_lo", long_outstanding, 0);
        chk("x0_err", err, 0);

        // Flush keeps long ops, drops short ops and the flush-cycle issue
        do_reset();
        step(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 9, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        #3;
        chk("flush_busy3", busy[3], 0);
        chk("flush_busy4", busy[4], 1);
        chk("flush_busy9", busy[9], 0);
        chk("flush_lo", long_outstanding, 1);
        for (int c = 0; c < 3; c++) begin
            idle();
            #3;
            chk("flush_err_sticky", err, 1);
        end
        do_reset();
        idle();
        #3;
        chk("err_cleared", err, 0);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            bit       v, u1, u2, lg, wv, fl, rst;
            bit [4:0] r1, r2, rd, wr;
            v   = $urandom_range(0, 3) != 0;
            u1  = $urandom_range(0, 1);
            u2  = $urandom_range(0, 1);
            r1  = 5'($urandom_range(0, 9));
            r2  = 5'($urandom_range(0, 9));
            rd  = 5'($urandom_range(0, 9));
            lg  = $urandom_range(0, 2) == 0;
            wv  = $urandom_range(0, 3) == 0;
            wr  = ($urandom_range(0, 9) == 0) ? 5'($urandom) :
                  5'($urandom_range(0, 9));
            fl  = $urandom_range(0, 15) == 0;
            rst = $urandom_range(0, 149) == 0;
            step(v, u1, r1, u2, r2, rd, lg, wv, wr, fl, rst);
        end

        idle();
        idle();
        @(negedge clock);
        #5;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
